// File: rtl/rom_glyph_sequencer.sv
// rom_glyph_sequencer
// Read-side controller for the glyph ROM. It walks ROM addresses 0..7,
// latches each segment/character pair onto the display outputs and holds
// it there for HOLD_TICKS timebase ticks before moving to the next entry.
// Blank segment entries can be skipped, and the walk can run once or loop.
module rom_glyph_sequencer #(
  parameter int HOLD_TICKS = 4,
  parameter int LOOP       = 0,
  parameter int SKIP_BLANK = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       start,
  input  logic       stop,
  input  logic       tick,
  output logic [2:0] rom_addr,
  input  logic [7:0] rom_data1,
  input  logic [7:0] rom_data2,
  output logic [7:0] seg,
  output logic [7:0] char,
  output logic       frame_stb,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic       LOOP_EN   = (LOOP != 0);
  localparam logic       SKIP_EN   = (SKIP_BLANK != 0);
  // The entry is released on the tick that finds the counter at this value.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);
  localparam logic [2:0] LAST_ADDR = 3'd7;

  logic [1:0] state_q, state_d;
  logic [2:0] addr_q, addr_d;
  logic [7:0] seg_q, seg_d;
  logic [7:0] char_q, char_d;
  logic [7:0] cnt_q, cnt_d;
  logic       frame_q, frame_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [1:0] adv_state;
  logic [2:0] adv_addr;
  logic       adv_done;
  logic       entry_blank;
  logic       hold_expired;

  // Where the walk goes once the current address has been dealt with
  always_comb begin
    adv_state = S_FETCH;
    adv_addr  = addr_q + 3'd1;
    adv_done  = 1'b0;
    if (addr_q == LAST_ADDR) begin
      if (LOOP_EN) begin
        adv_addr = 3'd0;
      end else begin
        // Address stays on the last entry for the single FINISH cycle.
        adv_state = S_FINISH;
        adv_addr  = addr_q;
        adv_done  = 1'b1;
      end
    end
  end

  // Entry qualification: blank detection and end-of-hold detection
  always_comb begin
    entry_blank  = SKIP_EN && (rom_data1 == 8'h00);
    hold_expired = tick && (cnt_q == HOLD_LAST);
  end

  // Next-state logic; stop outranks every state-specific action
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    seg_d   = seg_q;
    char_d  = char_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    frame_d = 1'b0;
    done_d  = 1'b0;

    if (stop) begin
      state_d = S_IDLE;
      addr_d  = 3'd0;
      seg_d   = 8'h00;
      char_d  = 8'h00;
      cnt_d   = 8'h00;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_FETCH;
            addr_d  = 3'd0;
            busy_d  = 1'b1;
          end
        end

        S_FETCH: begin
          // ROM is combinational: rom_data1/2 already belong to addr_q.
          if (entry_blank) begin
            state_d = adv_state;
            addr_d  = adv_addr;
            done_d  = adv_done;
          end else begin
            state_d = S_HOLD;
            seg_d   = rom_data1;
            char_d  = rom_data2;
            cnt_d   = 8'h00;
            frame_d = 1'b1;
          end
        end

        S_HOLD: begin
          if (hold_expired) begin
            state_d = adv_state;
            addr_d  = adv_addr;
            done_d  = adv_done;
          end else if (tick) begin
            cnt_d = cnt_q + 8'd1;
          end
        end

        S_FINISH: begin
          // seg/char keep showing the last entry after the pass ends.
          state_d = S_IDLE;
          addr_d  = 3'd0;
          busy_d  = 1'b0;
        end

        default: begin
          state_d = S_IDLE;
          addr_d  = 3'd0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State registers; ena low freezes everything, including pending strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= 3'd0;
      seg_q   <= 8'h00;
      char_q  <= 8'h00;
      cnt_q   <= 8'h00;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      seg_q   <= seg_d;
      char_q  <= char_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Strobes are masked while frozen so a held pulse is not seen twice.
  assign rom_addr  = addr_q;
  assign seg       = seg_q;
  assign char      = char_q;
  assign busy      = busy_q;
  assign frame_stb = frame_q & ena;
  assign done      = done_q & ena;

endmodule

// File: tb/tb_rom_glyph_sequencer.sv
// Bench for rom_glyph_sequencer: three instances with different parameter
// sets share the stimulus; each test selects the instance it observes.
module tb_rom_glyph_sequencer;

  logic       clk = 1'b0;
  logic       rst, ena, start, stop, tick;
  logic [7:0] rom1 [0:7];
  logic [7:0] rom2 [0:3];

  logic [2:0] a_addr, b_addr, c_addr;
  logic [7:0] a_seg, b_seg, c_seg, a_char, b_char, c_char;
  logic       a_frame, b_frame, c_frame, a_busy, b_busy, c_busy, a_done, b_done, c_done;

  logic [2:0] o_addr;
  logic [7:0] o_seg, o_char;
  logic       o_frame, o_busy, o_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sel   = 0;

  int         fr_cyc[$];
  logic [7:0] fr_seg[$];
  logic [7:0] fr_char[$];
  int         done_cyc[$];
  int         tick_cyc[$];
  int         exp_cyc[$];
  logic [7:0] exp_seg[$];
  logic [7:0] exp_char[$];
  int         exp_done[$];

  localparam logic [7:0] PASS_SEG  [0:5] = '{8'h6F, 8'h39, 8'h30, 8'h31, 8'h37, 8'h3F};
  localparam logic [7:0] PASS_CHAR [0:5] = '{8'h42, 8'h4B, 8'h41, 8'h42, 8'h41, 8'h4B};

  always #5 clk = ~clk;

  rom_glyph_sequencer #(.HOLD_TICKS(2), .LOOP(0), .SKIP_BLANK(1)) dut_a (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop), .tick(tick),
    .rom_addr(a_addr), .rom_data1(rom1[a_addr]), .rom_data2(rom2[a_addr[1:0]]),
    .seg(a_seg), .char(a_char), .frame_stb(a_frame), .busy(a_busy), .done(a_done));

  rom_glyph_sequencer #(.HOLD_TICKS(1), .LOOP(0), .SKIP_BLANK(0)) dut_b (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop), .tick(tick),
    .rom_addr(b_addr), .rom_data1(rom1[b_addr]), .rom_data2(rom2[b_addr[1:0]]),
    .seg(b_seg), .char(b_char), .frame_stb(b_frame), .busy(b_busy), .done(b_done));

  rom_glyph_sequencer #(.HOLD_TICKS(2), .LOOP(1), .SKIP_BLANK(1)) dut_c (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .stop(stop), .tick(tick),
    .rom_addr(c_addr), .rom_data1(rom1[c_addr]), .rom_data2(rom2[c_addr[1:0]]),
    .seg(c_seg), .char(c_char), .frame_stb(c_frame), .busy(c_busy), .done(c_done));

  always_comb begin
    case (sel)
      1:       begin o_addr = b_addr; o_seg = b_seg; o_char = b_char; o_frame = b_frame; o_busy = b_busy; o_done = b_done; end
      2:       begin o_addr = c_addr; o_seg = c_seg; o_char = c_char; o_frame = c_frame; o_busy = c_busy; o_done = c_done; end
      default: begin o_addr = a_addr; o_seg = a_seg; o_char = a_char; o_frame = a_frame; o_busy = a_busy; o_done = a_done; end
    endcase
  end

  function automatic int hold_of(input int s);
    return (s == 1) ? 1 : 2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load_default_rom();
    rom1[0] = 8'h6F; rom1[1] = 8'h00; rom1[2] = 8'h39; rom1[3] = 8'h30;
    rom1[4] = 8'h31; rom1[5] = 8'h37; rom1[6] = 8'h3F; rom1[7] = 8'h00;
    rom2[0] = 8'h42; rom2[1] = 8'h41; rom2[2] = 8'h4B; rom2[3] = 8'h41;
  endtask

  task automatic do_reset();
    ena = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic clear_logs();
    fr_cyc.delete(); fr_seg.delete(); fr_char.delete();
    done_cyc.delete(); tick_cyc.delete();
  endtask

  // Runs ncyc cycles: period 0 gives random ticks, otherwise a tick every
  // period cycles; start is pulsed in cycles st_a and st_b.
  task automatic collect(input int ncyc, input int period, input int st_a, input int st_b);
    for (int i = 0; i < ncyc; i++) begin
      if (period == 0) tick = ($urandom_range(0, 1) == 1);
      else             tick = ((cyc % period) == 0);
      start = (cyc == st_a) || (cyc == st_b);
      if (tick) tick_cyc.push_back(cyc);
      step();
      if (o_frame === 1'b1) begin
        fr_cyc.push_back(cyc); fr_seg.push_back(o_seg); fr_char.push_back(o_char);
      end
      if (o_done === 1'b1) done_cyc.push_back(cyc);
    end
    tick = 1'b0;
    start = 1'b0;
  endtask

  // Reference: walk the ROM in address order. A FETCH costs one cycle; a
  // shown entry appears the cycle after its FETCH and is released by the
  // hold-th tick seen from its first display cycle; the next FETCH (or the
  // done cycle) follows that tick.
  task automatic model_pass(input int hold, input bit loop_en, input bit skip_en,
                            input int start_cyc, input int end_cyc);
    int t, addr, ti, cnt;
    exp_cyc.delete(); exp_seg.delete(); exp_char.delete(); exp_done.delete();
    t = start_cyc + 1;
    addr = 0;
    ti = 0;
    while (t <= end_cyc) begin
      if (skip_en && rom1[addr] == 8'h00) begin
        t++;
      end else begin
        if (t + 1 > end_cyc) return;
        exp_cyc.push_back(t + 1);
        exp_seg.push_back(rom1[addr]);
        exp_char.push_back(rom2[addr % 4]);
        while (ti < tick_cyc.size() && tick_cyc[ti] < t + 1) ti++;
        cnt = 0;
        while (ti < tick_cyc.size() && cnt < hold) begin cnt++; ti++; end
        if (cnt < hold) return;
        t = tick_cyc[ti - 1] + 1;
      end
      if (addr == 7) begin
        if (!loop_en) begin
          if (t <= end_cyc) exp_done.push_back(t);
          return;
        end
        addr = 0;
      end else begin
        addr++;
      end
    end
  endtask

  task automatic test_reset();
    sel = 0;
    load_default_rom();
    ena = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0;
    rst = 1'b1;
    step();
    step();
    total++; if (o_seg !== 8'h00)  begin bad++; $display("FAIL reset_seg: got %h want 00", o_seg); end
    total++; if (o_char !== 8'h00) begin bad++; $display("FAIL reset_char: got %h want 00", o_char); end
    total++; if (o_addr !== 3'd0)  begin bad++; $display("FAIL reset_addr: got %0d want 0", o_addr); end
    total++; if (o_frame !== 1'b0) begin bad++; $display("FAIL reset_frame: got %b want 0", o_frame); end
    total++; if (o_busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    total++; if (o_done !== 1'b0)  begin bad++; $display("FAIL reset_done: got %b want 0", o_done); end
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick = (i % 2 == 0);
      step();
      total++;
      if ({o_busy, o_frame, o_done, o_seg, o_char, o_addr} !== 22'd0) begin
        bad++; $display("FAIL idle_tick: got busy=%b seg=%h addr=%0d want all zero", o_busy, o_seg, o_addr);
      end
    end
    tick = 1'b0;
    start = 1'b1; step(); start = 1'b0; step();
    total++; if (o_seg !== 8'h6F) begin bad++; $display("FAIL pre_rst_seg: got %h want 6f", o_seg); end
    rst = 1'b1; step(); rst = 1'b0;
    total++;
    if (o_seg !== 8'h00 || o_busy !== 1'b0 || o_addr !== 3'd0) begin
      bad++; $display("FAIL rst_mid_hold: got seg=%h busy=%b addr=%0d want 00/0/0", o_seg, o_busy, o_addr);
    end
  endtask

  task automatic test_single_pass();
    int n;
    sel = 0;
    load_default_rom();
    do_reset();
    clear_logs();
    n = cyc;
    collect(80, 3, n, -1);
    model_pass(2, 1'b0, 1'b1, n, cyc);
    total++; if (fr_cyc.size() !== 6) begin bad++; $display("FAIL sp_frames: got %0d want 6", fr_cyc.size()); end
    total++; if (exp_cyc.size() !== fr_cyc.size()) begin bad++; $display("FAIL sp_model_frames: got %0d want %0d", fr_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < fr_cyc.size() && i < 6; i++) begin
      total++;
      if (fr_seg[i] !== PASS_SEG[i] || fr_char[i] !== PASS_CHAR[i]) begin
        bad++; $display("FAIL sp_entry%0d: got %h/%h want %h/%h", i, fr_seg[i], fr_char[i], PASS_SEG[i], PASS_CHAR[i]);
      end
    end
    for (int i = 0; i < fr_cyc.size() && i < exp_cyc.size(); i++) begin
      total++;
      if (fr_cyc[i] !== exp_cyc[i]) begin
        bad++; $display("FAIL sp_timing%0d: got cycle %0d want %0d", i, fr_cyc[i], exp_cyc[i]);
      end
    end
    total++; if (done_cyc.size() !== 1) begin bad++; $display("FAIL sp_done_count: got %0d want 1", done_cyc.size()); end
    if (done_cyc.size() == 1 && exp_done.size() == 1) begin
      total++; if (done_cyc[0] !== exp_done[0]) begin bad++; $display("FAIL sp_done_cycle: got %0d want %0d", done_cyc[0], exp_done[0]); end
    end
    total++; if (o_seg !== 8'h3F || o_busy !== 1'b0) begin bad++; $display("FAIL sp_final: got seg=%h busy=%b want 3f/0", o_seg, o_busy); end
  endtask

  task automatic test_no_skip();
    int n;
    sel = 1;
    load_default_rom();
    do_reset();
    clear_logs();
    n = cyc;
    collect(60, 3, n, -1);
    model_pass(1, 1'b0, 1'b0, n, cyc);
    total++; if (fr_cyc.size() !== 8) begin bad++; $display("FAIL ns_frames: got %0d want 8", fr_cyc.size()); end
    if (fr_cyc.size() == 8) begin
      total++; if (fr_seg[1] !== 8'h00 || fr_char[1] !== 8'h41) begin bad++; $display("FAIL ns_addr1: got %h/%h want 00/41", fr_seg[1], fr_char[1]); end
      total++; if (fr_seg[7] !== 8'h00 || fr_char[7] !== 8'h41) begin bad++; $display("FAIL ns_addr7: got %h/%h want 00/41", fr_seg[7], fr_char[7]); end
    end
    for (int i = 0; i < fr_cyc.size() && i < exp_cyc.size(); i++) begin
      total++;
      if (fr_cyc[i] !== exp_cyc[i] || fr_seg[i] !== exp_seg[i] || fr_char[i] !== exp_char[i]) begin
        bad++; $display("FAIL ns_entry%0d: got %0d %h/%h want %0d %h/%h", i, fr_cyc[i], fr_seg[i], fr_char[i], exp_cyc[i], exp_seg[i], exp_char[i]);
      end
    end
    total++;
    if (done_cyc.size() !== 1 || exp_done.size() !== 1 || done_cyc[0] !== exp_done[0]) begin
      bad++; $display("FAIL ns_done: got count %0d want one pulse at model cycle", done_cyc.size());
    end
  endtask

  task automatic test_loop_stop();
    int n, guard;
    sel = 2;
    load_default_rom();
    do_reset();
    clear_logs();
    n = cyc;
    guard = 0;
    while (fr_cyc.size() < 8 && guard < 300) begin
      collect(1, 3, n, -1);
      guard++;
    end
    total++; if (fr_cyc.size() < 8) begin bad++; $display("FAIL lp_timeout: got %0d frames want 8", fr_cyc.size()); end
    model_pass(2, 1'b1, 1'b1, n, cyc);
    for (int i = 0; i < fr_cyc.size() && i < exp_cyc.size(); i++) begin
      total++;
      if (fr_cyc[i] !== exp_cyc[i] || fr_seg[i] !== exp_seg[i] || fr_char[i] !== exp_char[i]) begin
        bad++; $display("FAIL lp_entry%0d: got %0d %h/%h want %0d %h/%h", i, fr_cyc[i], fr_seg[i], fr_char[i], exp_cyc[i], exp_seg[i], exp_char[i]);
      end
    end
    if (fr_cyc.size() >= 8) begin
      total++; if (fr_seg[6] !== 8'h6F || fr_char[6] !== 8'h42) begin bad++; $display("FAIL lp_wrap: got %h/%h want 6f/42", fr_seg[6], fr_char[6]); end
    end
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL lp_busy: got %b want 1", o_busy); end
    stop = 1'b1; step(); stop = 1'b0;
    total++;
    if (o_seg !== 8'h00 || o_char !== 8'h00 || o_busy !== 1'b0 || o_addr !== 3'd0 || o_done !== 1'b0) begin
      bad++; $display("FAIL lp_stop: got seg=%h char=%h busy=%b addr=%0d done=%b want 00/00/0/0/0", o_seg, o_char, o_busy, o_addr, o_done);
    end
    collect(20, 3, -1, -1);
    total++;
    if (done_cyc.size() !== 0 || fr_cyc.size() !== 8 || o_busy !== 1'b0) begin
      bad++; $display("FAIL lp_after_stop: got done=%0d frames=%0d busy=%b want 0/8/0", done_cyc.size(), fr_cyc.size(), o_busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    sel = 0;
    load_default_rom();
    do_reset();
    clear_logs();
    n = cyc;
    collect(80, 3, n, n + 5);
    model_pass(2, 1'b0, 1'b1, n, cyc);
    total++;
    if (fr_cyc.size() < 1 || fr_cyc[0] !== n + 2) begin
      bad++; $display("FAIL bb_latency: got frames=%0d first=%0d want first at %0d", fr_cyc.size(), (fr_cyc.size() > 0) ? fr_cyc[0] : -1, n + 2);
    end
    total++; if (fr_cyc.size() !== exp_cyc.size()) begin bad++; $display("FAIL bb_frames: got %0d want %0d", fr_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < fr_cyc.size() && i < exp_cyc.size(); i++) begin
      total++;
      if (fr_cyc[i] !== exp_cyc[i] || fr_seg[i] !== exp_seg[i] || fr_char[i] !== exp_char[i]) begin
        bad++; $display("FAIL bb_entry%0d: got %0d %h/%h want %0d %h/%h", i, fr_cyc[i], fr_seg[i], fr_char[i], exp_cyc[i], exp_seg[i], exp_char[i]);
      end
    end
    total++; if (done_cyc.size() !== 1) begin bad++; $display("FAIL bb_done: got %0d want 1", done_cyc.size()); end
  endtask

  task automatic test_freeze();
    sel = 0;
    load_default_rom();
    do_reset();
    start = 1'b1; step(); start = 1'b0; step();
    total++; if (o_frame !== 1'b1) begin bad++; $display("FAIL fz_first_frame: got %b want 1", o_frame); end
    ena = 1'b0; tick = 1'b1; #1;
    total++; if (o_frame !== 1'b0) begin bad++; $display("FAIL fz_frame_masked: got %b want 0", o_frame); end
    step(); step();
    ena = 1'b1; tick = 1'b0; #1;
    total++; if (o_frame !== 1'b1) begin bad++; $display("FAIL fz_frame_resume: got %b want 1", o_frame); end
    step();
    total++; if (o_frame !== 1'b0) begin bad++; $display("FAIL fz_frame_once: got %b want 0", o_frame); end
    tick = 1'b1; step();
    ena = 1'b0; tick = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if (o_seg !== 8'h6F || o_char !== 8'h42 || o_addr !== 3'd0 || o_busy !== 1'b1 || o_frame !== 1'b0) begin
        bad++; $display("FAIL fz_frozen%0d: got %h/%h addr=%0d busy=%b want 6f/42 addr=0 busy=1", i, o_seg, o_char, o_addr, o_busy);
      end
    end
    ena = 1'b1; tick = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (o_seg !== 8'h6F || o_addr !== 3'd0 || o_frame !== 1'b0) begin
        bad++; $display("FAIL fz_remaining%0d: got seg=%h addr=%0d want 6f/0", i, o_seg, o_addr);
      end
    end
    tick = 1'b1; step(); tick = 1'b0;
    total++; if (o_addr !== 3'd1) begin bad++; $display("FAIL fz_advance: got addr=%0d want 1", o_addr); end
    step(); step();
    total++;
    if (o_frame !== 1'b1 || o_seg !== 8'h39 || o_char !== 8'h4B) begin
      bad++; $display("FAIL fz_next_entry: got %b %h/%h want 1 39/4b", o_frame, o_seg, o_char);
    end
  endtask

  task automatic test_priority();
    sel = 0;
    load_default_rom();
    do_reset();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (o_busy !== 1'b0 || o_frame !== 1'b0 || o_addr !== 3'd0 || o_seg !== 8'h00) begin
        bad++; $display("FAIL pr_idle%0d: got busy=%b frame=%b addr=%0d seg=%h want all zero", i, o_busy, o_frame, o_addr, o_seg);
      end
      step();
    end
  endtask

  task automatic test_all_blank();
    int n;
    for (int i = 0; i < 8; i++) rom1[i] = 8'h00;
    sel = 0;
    do_reset();
    clear_logs();
    n = cyc;
    collect(20, 3, n, -1);
    total++; if (fr_cyc.size() !== 0) begin bad++; $display("FAIL ab_frames: got %0d want 0", fr_cyc.size()); end
    total++;
    if (done_cyc.size() !== 1 || done_cyc[0] !== n + 9) begin
      bad++; $display("FAIL ab_done: got count=%0d first=%0d want one at %0d", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, n + 9);
    end
    sel = 2;
    do_reset();
    clear_logs();
    n = cyc;
    collect(40, 2, n, -1);
    total++;
    if (fr_cyc.size() !== 0 || done_cyc.size() !== 0 || o_busy !== 1'b1) begin
      bad++; $display("FAIL ab_loop_spin: got frames=%0d done=%0d busy=%b want 0/0/1", fr_cyc.size(), done_cyc.size(), o_busy);
    end
    stop = 1'b1; step(); stop = 1'b0;
    total++; if (o_busy !== 1'b0 || o_addr !== 3'd0) begin bad++; $display("FAIL ab_loop_stop: got busy=%b addr=%0d want 0/0", o_busy, o_addr); end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 9; it++) begin
      sel = it % 3;
      for (int i = 0; i < 8; i++) rom1[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      for (int i = 0; i < 4; i++) rom2[i] = 8'($urandom_range(0, 255));
      do_reset();
      clear_logs();
      n = cyc;
      collect(160, 0, n, -1);
      model_pass(hold_of(sel), (sel == 2), (sel != 1), n, cyc);
      total++;
      if (fr_cyc.size() !== exp_cyc.size()) begin
        bad++; $display("FAIL rnd%0d_frames: got %0d want %0d", it, fr_cyc.size(), exp_cyc.size());
      end
      for (int i = 0; i < fr_cyc.size() && i < exp_cyc.size(); i++) begin
        total++;
        if (fr_cyc[i] !== exp_cyc[i] || fr_seg[i] !== exp_seg[i] || fr_char[i] !== exp_char[i]) begin
          bad++; $display("FAIL rnd%0d_entry%0d: got %0d %h/%h want %0d %h/%h", it, i, fr_cyc[i], fr_seg[i], fr_char[i], exp_cyc[i], exp_seg[i], exp_char[i]);
        end
      end
      total++;
      if (done_cyc.size() !== exp_done.size() || (done_cyc.size() == 1 && exp_done.size() == 1 && done_cyc[0] !== exp_done[0])) begin
        bad++; $display("FAIL rnd%0d_done: got count=%0d want %0d", it, done_cyc.size(), exp_done.size());
      end
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; start = 1'b0; stop = 1'b0; tick = 1'b0;
    load_default_rom();
    test_reset();
    test_single_pass();
    test_no_skip();
    test_loop_stop();
    test_back_to_back();
    test_freeze();
    test_priority();
    test_all_blank();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
